// File: rtl/timed_data_memory.sv
// timed_data_memory: word-organised data memory with a fixed access latency.
// A request is the tuple {word index, write enable, write data when writing}.
// The tuple is sampled on every edge. It must be held stable for LATENCY
// edges after capture before the access completes. Any change restarts
// the access. Completion and access counters are exposed for observation.
module timed_data_memory #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 14
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_in [0:3],
  input  logic        mem_write_en,
  output logic [7:0]  mem_data_out [0:3],
  output logic        mem_ready,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

  typedef enum logic {ST_WAIT, ST_DONE} state_t;

  state_t state, state_nxt;

  // Latched request tuple and the latency counter.
  logic [ADDR_BITS-1:0] lat_idx;
  logic                 lat_we;
  logic [7:0]           lat_data [0:3];
  logic [CW-1:0]        cnt;

  logic [7:0]           storage [0:DEPTH-1][0:3];

  logic [ADDR_BITS-1:0] idx;
  logic                 data_diff;
  logic                 change;
  logic                 complete;
  logic                 cnt_inc;
  logic                 do_write;
  logic                 do_read;

  // Byte offset and the address bits above the index are don't-care (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_BITS+2], mem_addr[1:0]};

  assign idx = mem_addr[ADDR_BITS+1:2];

  // Compare presented write data against the latched data, lane by lane.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    data_diff = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (mem_data_in[k] != lat_data[k]) data_diff = 1'b1;
    end
  end

  // Write data only counts as part of the request when writing.
  assign change = (idx != lat_idx) || (mem_write_en != lat_we) ||
                  (mem_write_en && data_diff);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (!rst_b) state <= ST_WAIT;
    else        state <= state_nxt;
  end

  // FSM next-state logic: any change restarts the wait, and a full wait completes.
  always_comb begin
    state_nxt = state;
    if (change)                                 state_nxt = ST_WAIT;
    else if (state == ST_WAIT && cnt == LAT_C)  state_nxt = ST_DONE;
  end

  // FSM output decode: completion strobes and counter advance.
  always_comb begin
    complete = 1'b0;
    cnt_inc  = 1'b0;
    if (state == ST_WAIT && !change) begin
      if (cnt == LAT_C) complete = 1'b1;
      else              cnt_inc  = 1'b1;
    end
    do_write = complete && mem_write_en;
    do_read  = complete && !mem_write_en;
  end

  // Latch the request tuple on change and advance the latency counter.
  // The reset tuple is a read of word 0, so a read of address 0 held
  // through reset release completes without a separate capture edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lat_idx <= '0;
      lat_we  <= 1'b0;
      for (int k = 0; k < 4; k++) lat_data[k] <= '0;
      cnt     <= CW'(1);
    end else if (change) begin
      lat_idx <= idx;
      lat_we  <= mem_write_en;
      for (int k = 0; k < 4; k++) lat_data[k] <= mem_data_in[k];
      cnt     <= CW'(1);
    end else if (cnt_inc) begin
      cnt     <= cnt + CW'(1);
    end
  end

  // Storage array: commits only on a completed write.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; its contents survive reset and stay undefined until written.
    if (do_write) begin
      for (int k = 0; k < 4; k++) storage[idx][k] <= mem_data_in[k];
    end
  end

  // Registered outputs: ready flag, read/write-first data and saturating counters.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_ready <= 1'b0;
      for (int k = 0; k < 4; k++) mem_data_out[k] <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      if (change)        mem_ready <= 1'b0;
      else if (complete) mem_ready <= 1'b1;

      if (do_write) begin
        for (int k = 0; k < 4; k++) mem_data_out[k] <= mem_data_in[k];
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end

      if (do_read) begin
        for (int k = 0; k < 4; k++) mem_data_out[k] <= storage[idx][k];
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/timed_data_memory.md
# timed_data_memory

Word-organised data memory that sits directly downstream of the processor core's data port. It consumes the core's `mem_addr`, `mem_data_in` and `mem_write_en`, and returns `mem_data_out` after a fixed, parameterised access latency. The latency models main-memory cost behind the core's MEM-stage cache, so cache fills and write-throughs exercise freeze behaviour. The block also exposes a completion flag and access counters for the bench.

## Interface
- `LATENCY`, default 4: clock edges from request capture to completion; legal range ≥1.
- `ADDR_BITS`, default 14: word-index width; depth is 2^ADDR_BITS words of 4 bytes.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_b`  input  1  reset; asynchronous, active-low.
- `mem_addr`  input  32  byte address.
  - Word index is `mem_addr[ADDR_BITS+1:2]`.
  - Bits [1:0] and the bits above the index are ignored, so higher addresses alias.
- `mem_data_in`  input  4×8 (`[7:0] [0:3]`)  write data; lane k maps to byte 4·index+k.
- `mem_write_en`  input  1  1 = write request, 0 = read request.
- `mem_data_out`  output  4×8 (`[7:0] [0:3]`)  registered read data; lane k is byte 4·index+k.
- `mem_ready`  output  1  registered; 1 while the currently presented request has completed.
- `rd_count`  output  16  completed reads; saturates at 0xFFFF.
- `wr_count`  output  16  completed writes; saturates at 0xFFFF.

## Operation
- There is no valid strobe. A request is the tuple {word index, `mem_write_en`, and `mem_data_in` when writing}. It is sampled every edge and compared against the latched tuple.
- Internal state:
  - latched tuple;
  - `cnt` register, width $clog2(LATENCY+1);
  - two-state FSM, WAIT and DONE.
- Change detected at an edge (any field differs, in either state):
  - latch the new tuple;
  - `cnt` ← 1;
  - FSM → WAIT;
  - `mem_ready` ← 0;
  - no storage change.
- WAIT, no change, `cnt` < LATENCY: `cnt` increments.
- WAIT, no change, `cnt` == LATENCY: completion.
  - Write: storage[index] ← `mem_data_in`; `mem_data_out` ← `mem_data_in` (write-first); `wr_count`++.
  - Read: `mem_data_out` ← storage[index]; `rd_count`++.
  - `mem_ready` ← 1; FSM → DONE.
- LATENCY = 1 special case: the capture edge sets `cnt` to 1, so completion occurs at the next edge with no change.
- DONE, no change: all outputs hold. The write is never repeated, counters do not increment, and storage is not re-read.
- A change during WAIT aborts the pending access. A write is discarded with no partial commit, and the counters are unchanged.
- Storage is not cleared by reset. Contents are undefined until written or loaded through the bench backdoor.

## Timing
- Reset values while `rst_b` = 0:
  - `mem_data_out` = 0 (all lanes);
  - `mem_ready` = 0;
  - `rd_count` = 0, `wr_count` = 0;
  - FSM = WAIT, `cnt` = 1;
  - latched tuple = {index 0, read, data 0}.
- Consequence of the reset tuple: a read of address 0 held through reset release completes at the LATENCY-th edge after release.
- Latency: a request captured at edge t completes at edge t+LATENCY, provided the inputs are stable across edges t+1..t+LATENCY. `mem_ready` and `mem_data_out` become visible after edge t+LATENCY.
- `mem_ready` falls at the same edge that captures a new request. It never stays high across a request change.
- Throughput: one access per LATENCY+1 edges when the driver changes the request on the edge after `mem_ready` rises.
- Reset asserted mid-WAIT: the pending write is lost, storage keeps prior contents, and the outputs go to their reset values asynchronously.
- Counter saturation: at 0xFFFF a completion leaves the counter unchanged.

## Test plan
- Reset then write: set LATENCY=4, hold write of {11,22,33,44} to 0x40 from reset release.
  - Capture occurs at edge 1 and `mem_ready` rises after edge 5.
  - `mem_data_out` = {11,22,33,44}, `wr_count` = 1.
- Read-back: after the write, switch to a read of 0x42 (same word).
  - `mem_ready` drops at the switch edge and rises 4 edges later.
  - `mem_data_out` = {11,22,33,44}, `rd_count` = 1.
- Abort: write {AA,BB,CC,DD} to 0x80, then change the address to 0x84 two edges later.
  - A subsequent read of 0x80 returns its prior contents.
  - `wr_count` reflects only the 0x84 write once it completes.
- Hold in DONE: keep a completed write presented for 20 edges.
  - `wr_count` increments exactly once and `mem_ready` stays 1.
- Aliasing and LATENCY=1: write to 0x0001_0000 with ADDR_BITS=14, then read 0x0.
  - The read returns the written data.
  - Each access completes one edge after capture.
- Reset mid-access: assert `rst_b`=0 asynchronously during WAIT of a write.
  - Outputs are 0 immediately, and the target word is unchanged on a later read.
